// File: rtl/didactic_gpio_pkg.sv
// Shared constants for the Didactic GPIO controller: APB register map and sizing.
package didactic_gpio_pkg;

    localparam int APB_ADDR_W = 5;
    localparam int MAX_GPIO   = 32;

    localparam logic [APB_ADDR_W-1:0] DIR_OFS      = 5'h00;
    localparam logic [APB_ADDR_W-1:0] OUT_OFS      = 5'h04;
    localparam logic [APB_ADDR_W-1:0] IN_OFS       = 5'h08;
    localparam logic [APB_ADDR_W-1:0] IRQ_EN_OFS   = 5'h0C;
    localparam logic [APB_ADDR_W-1:0] IRQ_RISE_OFS = 5'h10;
    localparam logic [APB_ADDR_W-1:0] IRQ_FALL_OFS = 5'h14;
    localparam logic [APB_ADDR_W-1:0] STATUS_OFS   = 5'h18;

    // Byte address with the sub-word bits forced to zero.
    function automatic logic [APB_ADDR_W-1:0] word_addr(input logic [APB_ADDR_W-1:0] addr);
        return {addr[APB_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input channel: two-flop synchroniser, persistence glitch filter
// and a one-cycle delayed copy of the filtered level for edge detection.
module gpio_in_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic filt,
    output logic filt_d
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILTER_CYCLES > 0) ? FILTER_CYCLES - 1 : 0);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             filt_reg;
    logic             filt_d_reg;
    logic             sync;

    assign sync = sync_reg[1];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            filt_reg   <= 1'b0;
            filt_d_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], din};
            filt_d_reg <= filt_reg;
            if (FILTER_CYCLES == 0) begin
                filt_reg <= sync;
                cnt_reg  <= '0;
            end else if (sync == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Mismatch has held for FILTER_CYCLES consecutive samples.
                filt_reg <= sync;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign filt   = filt_reg;
    assign filt_d = filt_d_reg;

endmodule

// File: rtl/didactic_gpio_ctrl.sv
// APB GPIO controller: per-channel direction/output registers, filtered inputs
// and sticky edge-triggered interrupt status with a level irq output.
module didactic_gpio_ctrl
    import didactic_gpio_pkg::*;
#(
    parameter int NUM_GPIO      = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [NUM_GPIO-1:0]   gpio_in,
    output logic [NUM_GPIO-1:0]   gpio_out,
    output logic [NUM_GPIO-1:0]   gpio_oe,
    output logic                  irq
);

    logic [NUM_GPIO-1:0] dir_reg;
    logic [NUM_GPIO-1:0] out_reg;
    logic [NUM_GPIO-1:0] irq_en_reg;
    logic [NUM_GPIO-1:0] irq_rise_reg;
    logic [NUM_GPIO-1:0] irq_fall_reg;
    logic [NUM_GPIO-1:0] status_reg;
    logic [NUM_GPIO-1:0] status_next;
    logic [NUM_GPIO-1:0] filt;
    logic [NUM_GPIO-1:0] filt_d;
    logic [NUM_GPIO-1:0] edge_set;
    logic [NUM_GPIO-1:0] wdata;

    logic                  access;
    logic                  addr_valid;
    logic                  wr_ok;
    logic [APB_ADDR_W-1:0] ofs;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, paddr[1:0], pwdata};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GPIO; gi++) begin : g_in
            gpio_in_filter #(
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_filter (
                .clk_in (clk_in),
                .reset  (reset),
                .din    (gpio_in[gi]),
                .filt   (filt[gi]),
                .filt_d (filt_d[gi])
            );
        end
    endgenerate

    assign access     = psel & penable;
    assign ofs        = word_addr(paddr);
    assign addr_valid = (ofs <= STATUS_OFS);
    assign wdata      = pwdata[NUM_GPIO-1:0];
    assign pready     = 1'b1;

    always_comb begin
        pslverr = 1'b0;
        if (access) begin
            pslverr = pwrite ? (!addr_valid || ofs == IN_OFS) : !addr_valid;
        end
    end

    assign wr_ok = access & pwrite & ~pslverr;

    // Edges are taken from the filtered level, so outputs looped back count too.
    assign edge_set = (filt & ~filt_d & irq_rise_reg) | (~filt & filt_d & irq_fall_reg);

    always_comb begin
        status_next = status_reg;
        if (wr_ok && ofs == STATUS_OFS) begin
            status_next = status_reg & ~wdata;
        end
        status_next = status_next | edge_set;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            dir_reg      <= '0;
            out_reg      <= '0;
            irq_en_reg   <= '0;
            irq_rise_reg <= '0;
            irq_fall_reg <= '0;
            status_reg   <= '0;
        end else begin
            if (wr_ok && ofs == DIR_OFS)      dir_reg      <= wdata;
            if (wr_ok && ofs == OUT_OFS)      out_reg      <= wdata;
            if (wr_ok && ofs == IRQ_EN_OFS)   irq_en_reg   <= wdata;
            if (wr_ok && ofs == IRQ_RISE_OFS) irq_rise_reg <= wdata;
            if (wr_ok && ofs == IRQ_FALL_OFS) irq_fall_reg <= wdata;
            status_reg <= status_next;
        end
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            case (ofs)
                DIR_OFS:      prdata = 32'(dir_reg);
                OUT_OFS:      prdata = 32'(out_reg);
                IN_OFS:       prdata = 32'(filt);
                IRQ_EN_OFS:   prdata = 32'(irq_en_reg);
                IRQ_RISE_OFS: prdata = 32'(irq_rise_reg);
                IRQ_FALL_OFS: prdata = 32'(irq_fall_reg);
                STATUS_OFS:   prdata = 32'(status_reg);
                default:      prdata = '0;
            endcase
        end
    end

    assign gpio_oe  = dir_reg;
    assign gpio_out = out_reg;
    assign irq      = |(status_reg & irq_en_reg);

endmodule

// File: doc/didactic_gpio_ctrl.md
# didactic_gpio_ctrl

Parametrised GPIO controller for the Didactic SoC FPGA build. It replaces a fixed-width pad passthrough with NUM_GPIO independently configurable channels. Each channel has a direction, an output value, a synchronised and glitch-filtered input, and edge-triggered interrupts. The block sits on the SoC APB peripheral bus; the top-level pad wrapper drives the FPGA inout pins from gpio_out/gpio_oe.

## Interface
Parameters:
- NUM_GPIO, 8: channel count, legal range 1..32; register bits at and above NUM_GPIO read 0 and ignore writes.
- FILTER_CYCLES, 4: input glitch filter length in clk_in cycles; 0 bypasses the filter.

Ports:
- clk_in  input  1  single block clock.
- reset  input  1  asynchronous, active-low reset.
- psel, penable, pwrite  input  1 each  APB control.
- paddr  input  5  byte address; bits [1:0] ignored.
- pwdata  input  32  write data.
- prdata  output  32  read data.
- pready  output  1  always 1 (zero wait states).
- pslverr  output  1  error response.
- gpio_in  input  NUM_GPIO  raw pad inputs, asynchronous to clk_in.
- gpio_out  output  NUM_GPIO  pad output values.
- gpio_oe  output  NUM_GPIO  pad output enables; 1 drives the pad.
- irq  output  1  level interrupt, OR of enabled pending status.

## Operation
- Register map (word offsets): 0x00 DIR (RW, 1 = output), 0x04 OUT (RW), 0x08 IN (RO, filtered input), 0x0C IRQ_EN (RW), 0x10 IRQ_RISE (RW), 0x14 IRQ_FALL (RW), 0x18 IRQ_STATUS (RW1C).
- gpio_oe = DIR; gpio_out = OUT. Both are registered and change one cycle after the APB access phase.
- Input path per channel:
  - Two-flop synchroniser, giving sync.
  - Filter: counter cnt. If sync == filt, cnt <= 0. Otherwise cnt increments; when cnt == FILTER_CYCLES-1 and the mismatch persists, filt <= sync and cnt <= 0.
  - With FILTER_CYCLES == 0, filt <= sync every cycle.
- Edge detect: filt_d is filt delayed one cycle. A rise (filt & ~filt_d) sets STATUS[i] if IRQ_RISE[i]; a fall sets it if IRQ_FALL[i]. RISE and FALL both set enables both edges.
- STATUS is sticky; writing 1 clears a bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- STATUS updates regardless of IRQ_EN. irq = |(STATUS & IRQ_EN), combinational from registers.
- Edge detection also runs on channels configured as outputs, since the pad loopback is visible.
- APB:
  - A write in the access phase (psel & penable & pwrite) takes effect at that edge.
  - A read returns prdata combinationally during the access phase; prdata is 0 when not in an access phase.
  - Writes to IN, or to any offset above 0x18, assert pslverr with no state change.
  - Reads above 0x18 assert pslverr with prdata = 0.
- Reset values: DIR, OUT, IRQ_EN, IRQ_RISE, IRQ_FALL, STATUS = 0; sync, filt, filt_d, cnt = 0; gpio_oe = 0, gpio_out = 0, irq = 0, prdata = 0, pslverr = 0, pready = 1.
- Reset asserted mid-filter or mid-edge clears all state immediately. An input high at reset release produces a rise after the sync/filter latency. That rise is only captured if IRQ_RISE is already set when it occurs; software is expected to clear STATUS after configuration.

## Timing
- gpio_in changes and is sampled at edge k; with sync = 2 stages:
  - sync changes at k+2.
  - filt, and therefore IN, changes at k+2+FILTER_CYCLES.
  - STATUS and irq change at k+3+FILTER_CYCLES.
- Pulses shorter than FILTER_CYCLES cycles (measured at sync) never reach filt.
- A write to OUT or DIR in the access phase at edge k is visible on gpio_out/gpio_oe after edge k.
- A W1C at edge k drops irq after edge k, unless a new edge is detected at the same edge k.

## Structure
- didactic_gpio_pkg holds:
  - register offset localparams (DIR_OFS … STATUS_OFS);
  - APB address width (5);
  - the maximum channel count (32).
- Sub-module gpio_in_filter: synchroniser, filter counter and filt_d for one channel, parameterised by FILTER_CYCLES. Instantiate it NUM_GPIO times with a generate loop.
- The top holds the APB decode, the registers, edge-to-status logic and irq.

## Test plan
- Reset: NUM_GPIO = 8. Hold reset low with gpio_in = 0xFF -> all outputs 0 and pready = 1. After release, IN reads 0x00 until cycle 2+4, then reads 0xFF.
- Direction/output: write DIR = 0x0F, OUT = 0xA5 -> gpio_oe = 0x0F and gpio_out = 0xA5 one cycle later. Read-back returns the same values; bits 31:8 read 0.
- Glitch filter: FILTER_CYCLES = 4. A 3-cycle high pulse on gpio_in[2] -> IN[2] stays 0 and no STATUS. A 5-cycle pulse -> IN[2] = 1 at k+6.
- Edge interrupts: IRQ_RISE = 0x01, IRQ_FALL = 0x02, IRQ_EN = 0x03. Toggle gpio_in[0] and gpio_in[1] up, then down -> STATUS = 0x01 after the rise and 0x03 after the fall; irq = 1. Write STATUS = 0x01 -> STATUS = 0x02, irq stays 1.
- Simultaneous set/clear: a W1C of bit 0 issued on the same edge a rise on channel 0 is detected -> STATUS[0] stays 1.
- Errors: write 0x08, read 0x1C, write 0x1C -> pslverr = 1 on each; registers unchanged; prdata = 0 for the read.
